// File: rtl/mem_wb_skid_stage.sv
// Two-entry MEM/WB pipeline register with skid buffer: fully registered
// outputs, in-order hand-off, flush, and a saturating backpressure counter.
module mem_wb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_do,
  input  logic [BYTE_W-1:0] in_dob,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_rg,
  input  logic [4:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_do,
  output logic [BYTE_W-1:0] out_dob,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_W-1:0]  out_rg,
  output logic [4:0]        out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [BYTE_W-1:0] b;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rg;
    logic [4:0]        ctrl;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_e;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, pop;

  assign in_e      = '{d: in_do, b: in_dob, alu: in_alu, rg: in_rg, ctrl: in_ctrl};
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy transitions and entry movement; flush overrides any load.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_e;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_e;
          end else if (accept) begin
            skid_d  = in_e;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles the head is held by downstream.
  always_comb begin
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State, entry and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= {$bits(entry_t){1'b0}};
      skid_q  <= {$bits(entry_t){1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Write enables are masked while no entry is presented.
  assign out_do    = main_q.d;
  assign out_dob   = main_q.b;
  assign out_alu   = main_q.alu;
  assign out_rg    = main_q.rg;
  assign out_ctrl  = {main_q.ctrl[4:2], main_q.ctrl[1:0] & {2{out_valid}}};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomized and directed bench for mem_wb_skid_stage against a queue model.
module tb_mem_wb_skid_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
    logic [31:0] alu;
    logic [3:0]  rg;
    logic [4:0]  ctrl;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  ent_t in_e;
  logic in_ready, out_valid;
  logic [31:0] out_do, out_alu;
  logic [7:0]  out_dob;
  logic [3:0]  out_rg;
  logic [4:0]  out_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ent_t q[$];
  ent_t last_e;
  int   m_cnt;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.DATA_W(32), .BYTE_W(8), .REG_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_do(in_e.d), .in_dob(in_e.b), .in_alu(in_e.alu), .in_rg(in_e.rg), .in_ctrl(in_e.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_do(out_do), .out_dob(out_dob), .out_alu(out_alu), .out_rg(out_rg), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of at most two entries; head fields persist once the FIFO drains.
  task automatic model_update();
    bit vld, rdy;
    if (rst) begin
      q.delete();
      last_e = '0;
      m_cnt  = 0;
    end else begin
      vld = (q.size() > 0);
      rdy = (q.size() < 2);
      if (vld && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (vld && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(in_e);
      end
      if (q.size() > 0) last_e = q[0];
    end
  endtask

  task automatic compare();
    bit v;
    v = (q.size() > 0);
    chk("out_valid", {63'd0, out_valid}, {63'd0, v});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_do", {32'd0, out_do}, {32'd0, last_e.d});
    chk("out_dob", {56'd0, out_dob}, {56'd0, last_e.b});
    chk("out_alu", {32'd0, out_alu}, {32'd0, last_e.alu});
    chk("out_rg", {60'd0, out_rg}, {60'd0, last_e.rg});
    chk("out_ctrl", {59'd0, out_ctrl}, {59'd0, last_e.ctrl[4:2], v ? last_e.ctrl[1:0] : 2'b00});
    chk("stall_cnt", {60'd0, stall_cnt}, m_cnt);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_in(input bit v, input logic [31:0] alu, input logic [4:0] ctrl);
    in_valid = v;
    in_e     = '{d: alu ^ 32'h5A5A_0000, b: alu[7:0] + 8'd3, alu: alu, rg: alu[3:0], ctrl: ctrl};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 32'hDEAD, 5'h1F);
    step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_alu", {32'd0, out_alu}, 64'd0);
    chk("rst_ctrl", {59'd0, out_ctrl}, 64'd0);
    rst = 1'b0;

    // Streaming 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, i, 5'h03);
      step();
      chk("stream_alu", {32'd0, out_alu}, i);
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    set_in(1'b0, 32'd0, 5'h00);
    step();
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    // Backpressure A then B
    out_ready = 1'b0;
    set_in(1'b1, 32'hA, 5'h03);
    step();
    chk("bp_a_head", {32'd0, out_alu}, 64'hA);
    set_in(1'b1, 32'hB, 5'h03);
    step();
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_cnt1", {60'd0, stall_cnt}, 64'd1);
    set_in(1'b0, 32'h0, 5'h00);
    step();
    chk("bp_cnt2", {60'd0, stall_cnt}, 64'd2);
    chk("bp_hold_a", {32'd0, out_alu}, 64'hA);

    // Release
    out_ready = 1'b1;
    step();
    chk("rel_b", {32'd0, out_alu}, 64'hB);
    step();
    chk("rel_empty", {63'd0, out_valid}, 64'd0);

    // Flush in FULL with an offer pending
    out_ready = 1'b0;
    set_in(1'b1, 32'hC1, 5'h1F); step();
    set_in(1'b1, 32'hC2, 5'h1F); step();
    set_in(1'b1, 32'hC3, 5'h1F); flush = 1'b1; step();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_we", {62'd0, out_ctrl[1:0]}, 64'd0);
    flush = 1'b0; set_in(1'b0, 32'h0, 5'h00); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_nothing", {63'd0, out_valid}, 64'd0);
    end

    // Saturation
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 32'h77, 5'h01); step();
    set_in(1'b0, 32'h0, 5'h00);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {60'd0, stall_cnt}, 64'd15);

    // Reset priority over flush with accept pending in ONE
    rst = 1'b1; flush = 1'b1; set_in(1'b1, 32'h99, 5'h1F); step();
    chk("rp_valid", {63'd0, out_valid}, 64'd0);
    chk("rp_ready", {63'd0, in_ready}, 64'd1);
    chk("rp_alu", {32'd0, out_alu}, 64'd0);
    chk("rp_do", {32'd0, out_do}, 64'd0);
    chk("rp_ctrl", {59'd0, out_ctrl}, 64'd0);
    chk("rp_cnt", {60'd0, stall_cnt}, 64'd0);
    rst = 1'b0; flush = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0 ? $urandom_range(0, 1) == 1 : 1'b0;
      in_e      = '{d: $urandom, b: 8'($urandom), alu: $urandom, rg: 4'($urandom), ctrl: 5'($urandom)};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
